gs_op_sched: RTL and testbench

- Sequencing controller for the Gram-Schmidt QR datapath.
- Streams the N×N input matrix into the datapath's matrix store.
- Issues the ordered NORM/DOT/SUB column operations to the shared arithmetic unit using a valid/ready issue and done-pulse completion handshake.
- Reads the resulting Q matrix back out and signals completion. One job in flight at a time.

---
 rtl/gs_op_sched.sv | 124 ++++++++++++
 tb/tb_gs_op_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gs_op_sched.sv
// gs_op_sched: sequences one Gram-Schmidt QR job: matrix load, ordered NORM/DOT/SUB
// column-op issue with valid/ready + done-pulse handshake, then column-major Q readback.
module gs_op_sched #(
   parameter int N          = 3,
   parameter int ADDR_WIDTH = 4,
   parameter int CW         = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  op_valid,
   output logic [1:0]            op_code,
   output logic [CW-1:0]         op_col_i,
   output logic [CW-1:0]         op_col_j,
   input  logic                  op_ready,
   input  logic                  op_done,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, OUT, FIN} state_t;
   localparam logic [1:0] NORM = 2'b01, DOT = 2'b10, SUB = 2'b11;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N * N - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(N - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]            code_q, code_d;
   logic [CW-1:0]         i_q, i_d, j_q, j_d;
   logic                  err_q, err_d, out_valid_q, out_valid_d;
   logic                  last_op;

   assign last_op = code_q == NORM && j_q == LAST_COL;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      code_d      = code_q;
      i_d         = i_q;
      j_d         = j_q;
      err_d       = err_q | (op_done && state_q != WAIT);
      out_valid_d = state_q == OUT;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            cnt_d   = '0;
            code_d  = NORM;
            i_d     = '0;
            j_d     = '0;
            err_d   = op_done;
         end
         LOAD: if (in_valid) begin
            cnt_d = cnt_q == LAST_ADDR ? '0 : cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) state_d = ISSUE;
         end
         ISSUE: if (op_ready) state_d = WAIT;
         WAIT: if (op_done) begin
            state_d = last_op ? OUT : ISSUE;
            cnt_d   = '0;
            // NORM(j) opens column j+1 at DOT(0,j+1); SUB(i,j) moves to the next basis or closes with NORM(j)
            if (!last_op) begin
               if (code_q == NORM) begin
                  code_d = DOT;
                  i_d    = '0;
                  j_d    = j_q + CW'(1);
               end else if (code_q == DOT) begin
                  code_d = SUB;
               end else if (i_q + CW'(1) < j_q) begin
                  code_d = DOT;
                  i_d    = i_q + CW'(1);
               end else begin
                  code_d = NORM;
                  i_d    = j_q;
               end
            end
         end
         OUT: begin
            cnt_d = cnt_q == LAST_ADDR ? '0 : cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) state_d = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         code_q      <= '0;
         i_q         <= '0;
         j_q         <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         code_q      <= code_d;
         i_q         <= i_d;
         j_q         <= j_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign wr_en     = state_q == LOAD && in_valid;
   assign wr_addr   = state_q == LOAD ? cnt_q : '0;
   assign op_valid  = state_q == ISSUE;
   assign op_code   = op_valid ? code_q : '0;
   assign op_col_i  = op_valid ? i_q : '0;
   assign op_col_j  = op_valid ? j_q : '0;
   assign rd_en     = state_q == OUT;
   assign rd_addr   = rd_en ? cnt_q : '0;
   assign out_valid = out_valid_q;
   assign busy      = state_q != IDLE;
   assign done      = state_q == FIN;
   assign err       = err_q;
endmodule

// File: tb/tb_gs_op_sched.sv
// tb_gs_op_sched: directed jobs; expectations queued at stimulus time and
// checked by an independent monitor whenever the DUT writes, issues, reads or finishes.
module tb_gs_op_sched;
   logic       clk, reset, start, in_valid, op_ready, done_r, inj_done, bp_en;
   logic       wr_en, op_valid, rd_en, out_valid, busy, done, err;
   logic [3:0] wr_addr, rd_addr;
   logic [1:0] op_code, op_col_i, op_col_j;
   int         n_chk = 0, n_fail = 0, acc_cnt = 0, done_cnt = 0;
   int         exp_wr[$], exp_rd[$], exp_op[$], exp_done[$];

   localparam logic [5:0] OPS [9] = '{6'b01_00_00, 6'b10_00_01, 6'b11_00_01, 6'b01_01_01,
                                      6'b10_00_10, 6'b11_00_10, 6'b10_01_10, 6'b11_01_10,
                                      6'b01_10_10};

   gs_op_sched dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .op_valid(op_valid), .op_code(op_code),
      .op_col_i(op_col_i), .op_col_j(op_col_j), .op_ready(op_ready),
      .op_done(done_r | inj_done), .rd_en(rd_en), .rd_addr(rd_addr),
      .out_valid(out_valid), .busy(busy), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // arithmetic-unit model: op_done two cycles after accept, optional 3-cycle stall on DOT(0,2)
   initial begin
      int cd, held;
      cd = 0; held = 0; op_ready = 1'b1; done_r = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) cd = 0;
         else if (op_valid && op_ready) cd = 2;
         cyc();
         done_r = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) done_r = 1'b1;
         end
         if (!bp_en) held = 0;
         op_ready = !(bp_en && held < 3 && op_valid && {op_code, op_col_i, op_col_j} == 6'b10_00_10);
         if (!op_ready) held++;
      end
   end

   initial begin
      logic       prev_rd, prev_done;
      logic [5:0] cur, prev_op;
      int         ov_run, vrun;
      prev_rd = 0; prev_done = 0; prev_op = '0; ov_run = 0; vrun = 0;
      forever begin
         @(negedge clk);
         cur = {op_code, op_col_i, op_col_j};
         if (!reset) begin
            if (prev_done) chk("busy_after_done", 32'(busy), 0);
            chk("out_valid_lag", 32'(out_valid), 32'(prev_rd));
            if (wr_en) begin
               if (exp_wr.size() == 0) chk("unexpected_wr", 1, 0);
               else chk("wr_addr", 32'(wr_addr), exp_wr.pop_front());
            end
            if (op_valid) begin
               chk("issue_after_load", 32'(exp_wr.size()), 0);
               vrun++;
               if (vrun > 1) chk("op_stable", 32'(cur), 32'(prev_op));
               prev_op = cur;
               if (op_ready) begin
                  if (exp_op.size() == 0) chk("unexpected_op", 1, 0);
                  else chk("op_order", 32'(cur), exp_op.pop_front());
                  if (bp_en && cur == 6'b10_00_10) chk("bp_hold_cycles", 32'(vrun), 4);
                  acc_cnt++;
                  vrun = 0;
               end
            end else begin
               vrun = 0;
               chk("op_idle_zero", 32'(cur), 0);
            end
            if (rd_en) begin
               if (exp_rd.size() == 0) chk("unexpected_rd", 1, 0);
               else chk("rd_addr", 32'(rd_addr), exp_rd.pop_front());
            end
            if (out_valid) ov_run++;
            if (done) begin
               chk("done_with_last_ov", 32'(ov_run), 9);
               ov_run = 0;
               if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
               else chk("err_at_done", 32'(err), exp_done.pop_front());
               done_cnt++;
            end
         end
         prev_rd = rd_en;
         prev_done = done;
      end
   end

   task automatic run_job(input bit gap, input bit inj, input bit bp, input bit sb, input bit abort);
      int  acc0, done0;
      bit  st_i, st_o;
      for (int a = 0; a < 9; a++) begin
         exp_wr.push_back(a);
         exp_rd.push_back(a);
         exp_op.push_back(32'(OPS[a]));
      end
      exp_done.push_back(32'(inj));
      bp_en = bp; acc0 = acc_cnt; done0 = done_cnt; st_i = 0; st_o = 0;
      start = 1; in_valid = 1;
      cyc();
      start = 0; in_valid = 0;
      chk("busy_on_start", 32'(busy), 1);
      chk("err_clear_on_start", 32'(err), 0);
      for (int k = 0; k < 9; k++) begin
         if (gap) cyc();
         in_valid = 1;
         inj_done = inj && k == 3;
         cyc();
         in_valid = 0;
         inj_done = 0;
      end
      chk("err_after_load", 32'(err), 32'(inj));
      if (abort) begin
         for (int c = 0; c < 50 && acc_cnt - acc0 < 3; c++) cyc();
         chk("reached_sub01_wait", 32'(acc_cnt - acc0), 3);
         reset = 1;
         cyc();
         reset = 0;
         chk("abort_outputs_zero", 32'({wr_en, wr_addr, op_valid, op_code, op_col_i, op_col_j,
                                        rd_en, rd_addr, out_valid, busy, done, err}), 0);
         exp_wr.delete(); exp_rd.delete(); exp_op.delete(); exp_done.delete();
         return;
      end
      for (int c = 0; c < 300 && done_cnt == done0; c++) begin
         start = sb && ((op_valid && !st_i) || (rd_en && !st_o));
         if (start && op_valid) st_i = 1;
         if (start && rd_en) st_o = 1;
         cyc();
      end
      start = 0;
      chk("done_seen", 32'(done_cnt - done0), 1);
      repeat (3) cyc();
      chk("single_done", 32'(done_cnt - done0), 1);
      chk("idle_after_job", 32'(busy), 0);
      chk("err_sticky", 32'(err), 32'(inj));
      chk("wr_q_drained", 32'(exp_wr.size()), 0);
      chk("op_q_drained", 32'(exp_op.size()), 0);
      chk("rd_q_drained", 32'(exp_rd.size()), 0);
      chk("done_q_drained", 32'(exp_done.size()), 0);
      bp_en = 0;
   endtask

   initial begin
      reset = 1; start = 0; in_valid = 0; inj_done = 0; bp_en = 0;
      cyc();
      cyc();
      chk("reset_outputs_zero", 32'({wr_en, wr_addr, op_valid, op_code, op_col_i, op_col_j,
                                     rd_en, rd_addr, out_valid, busy, done, err}), 0);
      reset = 0;
      cyc();
      run_job(0, 0, 0, 0, 0);
      run_job(0, 0, 1, 0, 0);
      run_job(1, 0, 0, 0, 0);
      run_job(0, 1, 0, 0, 0);
      run_job(0, 0, 0, 0, 0);
      run_job(0, 0, 0, 0, 1);
      run_job(0, 0, 0, 0, 0);
      run_job(0, 0, 0, 1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
